// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - IF/MEM arbiter for one shared single-port variable-latency memory
//
// Purpose: serialises instruction fetches and data accesses onto a single memory
// port. Data accesses win because they belong to the older instruction. The block
// also produces the pipeline stall signals and a sticky timeout error.
//
// Ports:
//   clk, clrn              clock; synchronous active-high reset
//   if_req, if_addr        fetch request and PC from the IF stage
//   mem_rd, mem_wr         load / store in MEM (both high is treated as a store)
//   mem_addr, mem_wdata    data address and store data from EX/MEM
//   ram_req, ram_we        memory request and write enable (registered)
//   ram_addr, ram_wdata    memory address and write data (registered)
//   ram_ready, ram_rdata   memory completion strobe and read data
//   inst, inst_valid       latched instruction; valid until IF consumes it
//   mdata, mdata_valid     load data with a one-cycle valid pulse
//   stall_if               freeze PC and IF/ID
//   stall_pipe             freeze PC, IF/ID, ID/EX and EX/MEM
//   err                    sticky memory timeout, cleared only by reset
module pipe_mem_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic          ram_ready,
  input  logic [31:0]   ram_rdata,
  output logic [31:0]   inst,
  output logic          inst_valid,
  output logic [31:0]   mdata,
  output logic          mdata_valid,
  output logic          stall_if,
  output logic          stall_pipe,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, ERR} state_t;

  // Last count value before the timeout fires: the counter "reaches" MAX_WAIT
  // on the edge that moves the FSM into ERR.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  state_t     state_next;
  logic       d_done;
  logic [7:0] wait_cnt;
  logic       d_req;
  logic       start_d;
  logic       start_i;
  logic       acc_done;
  logic       timeout;

  assign d_req = mem_rd | mem_wr;

  // d_done drops the stall in the completion cycle so EX/MEM advances and
  // MEM/WB captures mdata; it also stops the same instruction re-issuing.
  assign stall_pipe = err | (d_req & ~d_done);
  assign stall_if   = stall_pipe | (if_req & ~inst_valid);

  always_ff @(posedge clk) begin
    if (clrn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_d    = 1'b0;
    start_i    = 1'b0;
    acc_done   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !d_done) begin
          state_next = DACC;
          start_d    = 1'b1;
        end else if (if_req && !inst_valid) begin
          state_next = IACC;
          start_i    = 1'b1;
        end
      end
      DACC, IACC: begin
        if (ram_ready) begin
          state_next = IDLE;
          acc_done   = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ERR;
          timeout    = 1'b1;
        end
      end
      ERR: state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      inst        <= '0;
      inst_valid  <= 1'b0;
      mdata       <= '0;
      mdata_valid <= 1'b0;
      err         <= 1'b0;
      d_done      <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      d_done      <= 1'b0;
      mdata_valid <= 1'b0;

      if (start_d) begin
        ram_req   <= 1'b1;
        ram_we    <= mem_wr;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
        wait_cnt  <= '0;
      end else if (start_i) begin
        ram_req  <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= if_addr;
        wait_cnt <= '0;
      end else if (acc_done) begin
        ram_req <= 1'b0;
        ram_we  <= 1'b0;
        if (state == DACC) begin
          // A request withdrawn mid-access is discarded so it cannot mask
          // a different request that appears in the following cycle.
          d_done <= d_req;
          if (!ram_we && d_req) begin
            mdata       <= ram_rdata;
            mdata_valid <= 1'b1;
          end
        end else begin
          inst <= ram_rdata;
        end
      end else if (timeout) begin
        ram_req <= 1'b0;
        ram_we  <= 1'b0;
        err     <= 1'b1;
      end else if (state == DACC || state == IACC) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // A fetch completing in the same cycle IF consumes the old one wins.
      if (acc_done && state == IACC) begin
        inst_valid <= 1'b1;
      end else if (!stall_if) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb/tb_pipe_mem_arbiter.sv - directed self-checking bench for pipe_mem_arbiter
`timescale 1ns/1ps
module tb_pipe_mem_arbiter;
  localparam int AW = 32;
  localparam int MAX_WAIT = 15;

  logic          clk = 1'b0;
  logic          clrn;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_ready;
  logic [31:0]   ram_rdata;
  logic [31:0]   inst;
  logic          inst_valid;
  logic [31:0]   mdata;
  logic          mdata_valid;
  logic          stall_if;
  logic          stall_pipe;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory responder: ready after 'lat' cycles of ram_req, data from rdata_val.
  int          lat = 1;
  logic        ready_en = 1'b1;
  logic [31:0] rdata_val = 32'h0;
  int          req_cnt = 0;

  always #5 clk = ~clk;

  assign ram_ready = ready_en && ram_req && (req_cnt == lat - 1);
  assign ram_rdata = rdata_val;

  always @(posedge clk) begin
    if (!ram_req || ram_ready) req_cnt <= 0;
    else req_cnt <= req_cnt + 1;
  end

  pipe_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .clk(clk), .clrn(clrn),
    .if_req(if_req), .if_addr(if_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ready(ram_ready), .ram_rdata(ram_rdata),
    .inst(inst), .inst_valid(inst_valid),
    .mdata(mdata), .mdata_valid(mdata_valid),
    .stall_if(stall_if), .stall_pipe(stall_pipe), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clrn = 1'b1; if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_wdata = '0; ready_en = 1'b1; lat = 1; rdata_val = '0;
    tick; tick;
    n_cmp++; if ({ram_req, ram_we, inst_valid, mdata_valid, err} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want %b", {ram_req, ram_we, inst_valid, mdata_valid, err}, 5'b0); end
    n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL reset_ram_addr: got %h want %h", ram_addr, 32'h0); end
    n_cmp++; if (ram_wdata !== '0) begin n_bad++; $display("FAIL reset_ram_wdata: got %h want %h", ram_wdata, 32'h0); end
    n_cmp++; if (inst !== '0) begin n_bad++; $display("FAIL reset_inst: got %h want %h", inst, 32'h0); end
    n_cmp++; if (mdata !== '0) begin n_bad++; $display("FAIL reset_mdata: got %h want %h", mdata, 32'h0); end
    n_cmp++; if ({stall_if, stall_pipe} !== 2'b00) begin n_bad++; $display("FAIL reset_stalls: got %b want %b", {stall_if, stall_pipe}, 2'b00); end
    clrn = 1'b0;
    tick;
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: got %b want %b", ram_req, 1'b0); end
  endtask

  task automatic test_fetch;
    int  reqc;
    bit  seen;
    lat = 3; rdata_val = 32'h8C220004; if_req = 1'b1; if_addr = 32'h40;
    #1;
    n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_if_early: got %b want %b", stall_if, 1'b1); end
    reqc = 0; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (inst_valid) begin seen = 1'b1; break; end
      if (ram_req) begin
        reqc++;
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL fetch_we: got %b want %b", ram_we, 1'b0); end
        n_cmp++; if (ram_addr !== 32'h40) begin n_bad++; $display("FAIL fetch_addr: got %h want %h", ram_addr, 32'h40); end
      end
      n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_if: got %b want %b", stall_if, 1'b1); end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL fetch_done_timeout: got %b want %b", seen, 1'b1); end
    n_cmp++; if (reqc !== 3) begin n_bad++; $display("FAIL fetch_req_cycles: got %0d want %0d", reqc, 3); end
    n_cmp++; if (inst !== 32'h8C220004) begin n_bad++; $display("FAIL fetch_inst: got %h want %h", inst, 32'h8C220004); end
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL fetch_req_drop: got %b want %b", ram_req, 1'b0); end
    n_cmp++; if (stall_if !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_if_release: got %b want %b", stall_if, 1'b0); end
    if_req = 1'b0;
    tick;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_consume: got %b want %b", inst_valid, 1'b0); end
  endtask

  task automatic test_load;
    int stallc;
    bit seen;
    lat = 3; rdata_val = 32'hDEADBEEF; mem_rd = 1'b1; mem_addr = 32'h100;
    #1;
    stallc = stall_pipe ? 1 : 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (mdata_valid) begin seen = 1'b1; break; end
      if (stall_pipe) stallc++;
      if (ram_req) begin
        n_cmp++; if ({ram_we, ram_addr} !== {1'b0, 32'h100}) begin n_bad++; $display("FAIL load_req: got we=%b addr=%h want we=0 addr=00000100", ram_we, ram_addr); end
      end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL load_done_timeout: got %b want %b", seen, 1'b1); end
    n_cmp++; if (stallc !== 4) begin n_bad++; $display("FAIL load_stall_cycles: got %0d want %0d", stallc, 4); end
    n_cmp++; if (stall_pipe !== 1'b0) begin n_bad++; $display("FAIL load_stall_drop: got %b want %b", stall_pipe, 1'b0); end
    n_cmp++; if (mdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_mdata: got %h want %h", mdata, 32'hDEADBEEF); end
    tick;
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL load_no_repeat: got %b want %b", ram_req, 1'b0); end
    n_cmp++; if (mdata_valid !== 1'b0) begin n_bad++; $display("FAIL load_valid_pulse: got %b want %b", mdata_valid, 1'b0); end
    mem_rd = 1'b0;
    tick;
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL load_idle_after: got %b want %b", ram_req, 1'b0); end
  endtask

  task automatic test_back_to_back;
    lat = 2; rdata_val = 32'hCAFEF00D;
    if_req = 1'b1; if_addr = 32'h300; mem_wr = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h12345678;
    tick;
    n_cmp++; if ({ram_req, ram_we} !== 2'b11) begin n_bad++; $display("FAIL b2b_write_req: got %b want %b", {ram_req, ram_we}, 2'b11); end
    n_cmp++; if (ram_addr !== 32'h200) begin n_bad++; $display("FAIL b2b_write_addr: got %h want %h", ram_addr, 32'h200); end
    n_cmp++; if (ram_wdata !== 32'h12345678) begin n_bad++; $display("FAIL b2b_write_data: got %h want %h", ram_wdata, 32'h12345678); end
    tick;
    n_cmp++; if (ram_req !== 1'b1) begin n_bad++; $display("FAIL b2b_write_hold: got %b want %b", ram_req, 1'b1); end
    tick;
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: got %b want %b", ram_req, 1'b0); end
    n_cmp++; if (mdata_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_no_mdata: got %b want %b", mdata_valid, 1'b0); end
    n_cmp++; if (stall_pipe !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_drop: got %b want %b", stall_pipe, 1'b0); end
    tick;
    mem_wr = 1'b0;
    n_cmp++; if ({ram_req, ram_we} !== 2'b10) begin n_bad++; $display("FAIL b2b_fetch_req: got %b want %b", {ram_req, ram_we}, 2'b10); end
    n_cmp++; if (ram_addr !== 32'h300) begin n_bad++; $display("FAIL b2b_fetch_addr: got %h want %h", ram_addr, 32'h300); end
    tick; tick;
    n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_inst_valid: got %b want %b", inst_valid, 1'b1); end
    n_cmp++; if (inst !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_inst: got %h want %h", inst, 32'hCAFEF00D); end
    if_req = 1'b0;
    tick;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_consume: got %b want %b", inst_valid, 1'b0); end
  endtask

  task automatic test_load_during_fetch;
    lat = 3; rdata_val = 32'h11111111; if_req = 1'b1; if_addr = 32'h44;
    tick;
    n_cmp++; if ({ram_req, ram_addr} !== {1'b1, 32'h44}) begin n_bad++; $display("FAIL ldf_fetch_start: got req=%b addr=%h want req=1 addr=00000044", ram_req, ram_addr); end
    mem_rd = 1'b1; mem_addr = 32'h104;
    #1;
    n_cmp++; if (stall_pipe !== 1'b1) begin n_bad++; $display("FAIL ldf_stall_pipe: got %b want %b", stall_pipe, 1'b1); end
    tick; tick;
    n_cmp++; if ({ram_req, ram_we, ram_addr} !== {2'b10, 32'h44}) begin n_bad++; $display("FAIL ldf_no_preempt: got req=%b we=%b addr=%h want 1 0 00000044", ram_req, ram_we, ram_addr); end
    tick;
    n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL ldf_inst_valid: got %b want %b", inst_valid, 1'b1); end
    n_cmp++; if (inst !== 32'h11111111) begin n_bad++; $display("FAIL ldf_inst: got %h want %h", inst, 32'h11111111); end
    n_cmp++; if ({ram_req, stall_pipe} !== 2'b01) begin n_bad++; $display("FAIL ldf_gap: got %b want %b", {ram_req, stall_pipe}, 2'b01); end
    rdata_val = 32'h22222222;
    tick;
    n_cmp++; if ({ram_req, ram_we, ram_addr} !== {2'b10, 32'h104}) begin n_bad++; $display("FAIL ldf_data_start: got req=%b we=%b addr=%h want 1 0 00000104", ram_req, ram_we, ram_addr); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL ldf_inst_held: got %b want %b", inst_valid, 1'b1); end
    tick; tick; tick;
    n_cmp++; if ({mdata_valid, stall_pipe, stall_if} !== 3'b100) begin n_bad++; $display("FAIL ldf_data_done: got %b want %b", {mdata_valid, stall_pipe, stall_if}, 3'b100); end
    n_cmp++; if (mdata !== 32'h22222222) begin n_bad++; $display("FAIL ldf_mdata: got %h want %h", mdata, 32'h22222222); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL ldf_inst_until_release: got %b want %b", inst_valid, 1'b1); end
    tick;
    n_cmp++; if ({inst_valid, ram_req} !== 2'b00) begin n_bad++; $display("FAIL ldf_consume: got %b want %b", {inst_valid, ram_req}, 2'b00); end
    if_req = 1'b0; mem_rd = 1'b0;
    tick;
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL ldf_idle: got %b want %b", ram_req, 1'b0); end
  endtask

  task automatic test_timeout;
    int reqc;
    bit seen;
    ready_en = 1'b0; mem_rd = 1'b1; mem_addr = 32'h180;
    reqc = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (err) begin seen = 1'b1; break; end
      if (ram_req) reqc++;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL tmo_err_seen: got %b want %b", seen, 1'b1); end
    n_cmp++; if (reqc !== MAX_WAIT) begin n_bad++; $display("FAIL tmo_req_cycles: got %0d want %0d", reqc, MAX_WAIT); end
    n_cmp++; if ({ram_req, stall_pipe} !== 2'b01) begin n_bad++; $display("FAIL tmo_outputs: got %b want %b", {ram_req, stall_pipe}, 2'b01); end
    mem_rd = 1'b0;
    #1;
    n_cmp++; if (stall_pipe !== 1'b1) begin n_bad++; $display("FAIL tmo_stall_sticky: got %b want %b", stall_pipe, 1'b1); end
    ready_en = 1'b1;
    tick; tick;
    n_cmp++; if ({err, ram_req, stall_if} !== 3'b101) begin n_bad++; $display("FAIL tmo_err_sticky: got %b want %b", {err, ram_req, stall_if}, 3'b101); end
    clrn = 1'b1;
    tick;
    clrn = 1'b0;
    #1;
    n_cmp++; if ({err, ram_req, ram_we, stall_pipe, stall_if, inst_valid, mdata_valid} !== 7'b0) begin n_bad++; $display("FAIL tmo_recover: got %b want %b", {err, ram_req, ram_we, stall_pipe, stall_if, inst_valid, mdata_valid}, 7'b0); end
    n_cmp++; if ({inst, mdata, ram_addr} !== 96'h0) begin n_bad++; $display("FAIL tmo_recover_data: got %h %h %h want zeros", inst, mdata, ram_addr); end
  endtask

  task automatic test_reset_mid;
    lat = 4; rdata_val = 32'h5A5A5A5A; mem_rd = 1'b1; mem_addr = 32'h1C0;
    tick;
    n_cmp++; if (ram_req !== 1'b1) begin n_bad++; $display("FAIL rmid_start: got %b want %b", ram_req, 1'b1); end
    tick;
    clrn = 1'b1;
    tick;
    clrn = 1'b0; lat = 2;
    n_cmp++; if ({ram_req, mdata_valid} !== 2'b00) begin n_bad++; $display("FAIL rmid_abandon: got %b want %b", {ram_req, mdata_valid}, 2'b00); end
    tick;
    n_cmp++; if ({ram_req, ram_addr} !== {1'b1, 32'h1C0}) begin n_bad++; $display("FAIL rmid_restart: got req=%b addr=%h want req=1 addr=000001c0", ram_req, ram_addr); end
    n_cmp++; if (mdata_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_early_data: got %b want %b", mdata_valid, 1'b0); end
    tick; tick;
    n_cmp++; if ({mdata_valid, stall_pipe} !== 2'b10) begin n_bad++; $display("FAIL rmid_done: got %b want %b", {mdata_valid, stall_pipe}, 2'b10); end
    n_cmp++; if (mdata !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL rmid_mdata: got %h want %h", mdata, 32'h5A5A5A5A); end
    tick;
    mem_rd = 1'b0;
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL rmid_no_repeat: got %b want %b", ram_req, 1'b0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fetch;
    test_load;
    test_back_to_back;
    test_load_during_fetch;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
